pipe_hazard_scoreboard: RTL and testbench

//  Unified hazard/forwarding controller for the 5-stage MIPS core; replaces the separate hazard and forwarding units.

---
 rtl/pipe_hazard_scoreboard_pkg.sv | 40 ++++
 rtl/pipe_hazard_scoreboard_if.sv | 62 ++++++
 rtl/pipe_hazard_scoreboard_mdu_timer.sv | 40 ++++
 rtl/pipe_hazard_scoreboard.sv | 119 +++++++++++
 tb/tb_pipe_hazard_scoreboard.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_hazard_scoreboard_pkg.sv
`default_nettype none
// =====================================================================
// pipe_hazard_pkg : forwarding encodings, stage tag type, match helpers
// Revision: 1.0
// =====================================================================
package pipe_hazard_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam int REG_IDX_W = 5;

  typedef struct packed {
    logic [REG_IDX_W-1:0] dst;
    logic [REG_IDX_W-1:0] rs;
    logic [REG_IDX_W-1:0] rt;
    logic                 regwrite;
    logic                 load;
    logic                 mdu;
  } stage_tag_t;

  localparam stage_tag_t NOP_TAG = '0;

  // Register 0 is hard-wired, so it never produces a dependency.
  function automatic logic tag_match(input logic [REG_IDX_W-1:0] x, input stage_tag_t s);
    return (x != '0) && s.regwrite && (s.dst == x);
  endfunction

  // Youngest producer wins: MEM before WB.
  function automatic logic [1:0] fwd_select(input logic [REG_IDX_W-1:0] x,
                                            input stage_tag_t mem,
                                            input stage_tag_t wb);
    if (tag_match(x, mem))     return FWD_MEM;
    else if (tag_match(x, wb)) return FWD_WB;
    else                       return FWD_RF;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_hazard_scoreboard_if.sv
`default_nettype none
// =====================================================================
// pipe_hazard_scoreboard_if : ID-stage info in, pipeline controls out;
// counter signals present only with HAZ_PERF_CNT_EN
// Revision: 1.0
// =====================================================================
interface pipe_hazard_scoreboard_if #(
  parameter int RW = 5
`ifdef HAZ_PERF_CNT_EN
  , parameter int CNTW = 16
`endif
);
  logic          id_valid;
  logic [RW-1:0] id_rs;
  logic [RW-1:0] id_rt;
  logic          id_use_rs;
  logic          id_use_rt;
  logic          id_branch;
  logic          id_taken;
  logic [RW-1:0] id_dst;
  logic          id_regwrite;
  logic          id_load;
  logic          id_mdu;

  logic          pc_write;
  logic          ifid_write;
  logic          ifid_flush;
  logic          idex_bubble;
  logic          ex_hold;
  logic          exmem_bubble;
  logic [1:0]    fwd_a_ex;
  logic [1:0]    fwd_b_ex;
  logic [1:0]    fwd_a_id;
  logic [1:0]    fwd_b_id;
  logic          mdu_busy;
`ifdef HAZ_PERF_CNT_EN
  logic [CNTW-1:0] stall_cnt;
  logic [CNTW-1:0] flush_cnt;
`endif

  modport master (
    output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_branch, id_taken,
           id_dst, id_regwrite, id_load, id_mdu,
    input  pc_write, ifid_write, ifid_flush, idex_bubble, ex_hold, exmem_bubble,
           fwd_a_ex, fwd_b_ex, fwd_a_id, fwd_b_id, mdu_busy
`ifdef HAZ_PERF_CNT_EN
    , input stall_cnt, flush_cnt
`endif
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_branch, id_taken,
           id_dst, id_regwrite, id_load, id_mdu,
    output pc_write, ifid_write, ifid_flush, idex_bubble, ex_hold, exmem_bubble,
           fwd_a_ex, fwd_b_ex, fwd_a_id, fwd_b_id, mdu_busy
`ifdef HAZ_PERF_CNT_EN
    , output stall_cnt, flush_cnt
`endif
  );

endinterface
`default_nettype wire

// File: rtl/pipe_hazard_scoreboard_mdu_timer.sv
`default_nettype none
// =====================================================================
// hz_mdu_timer : down-counter tracking how long an MDU op occupies EX
// Revision: 1.0
// =====================================================================
module hz_mdu_timer #(
  parameter int MDU_LAT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy,
  output logic last
);
  localparam int            TW  = $clog2(MDU_LAT + 1);
  localparam logic [TW-1:0] LAT = TW'(MDU_LAT);

  logic [TW-1:0] cnt_q;
  logic [TW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start)
      cnt_d = LAT;
    else if (cnt_q != '0)
      cnt_d = cnt_q - TW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  always_comb begin
    busy = (cnt_q != '0);
    last = (cnt_q == TW'(1));
  end

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_scoreboard.sv
`default_nettype none
// =====================================================================
// pipe_hazard_scoreboard : unified hazard/forwarding control for the
// 5-stage core; HAZ_PERF_CNT_EN adds saturating stall/flush counters
// Revision: 1.0
// =====================================================================
module pipe_hazard_scoreboard
  import pipe_hazard_pkg::*;
#(
  parameter int RW      = REG_IDX_W,
  parameter int MDU_LAT = 4
`ifdef HAZ_PERF_CNT_EN
  , parameter int CNTW  = 16
`endif
) (
  input  logic                    clk,
  input  logic                    rst,
  pipe_hazard_scoreboard_if.slave hz
);

  stage_tag_t    ex_q, ex_d, mem_q, mem_d, wb_q, wb_d, id_tag;
  logic [RW-1:0] src_a, src_b;
  logic          ex_hit, mem_hit, load_use, branch_dep;
  logic          mdu_hold, stall, flush, mdu_start, mdu_busy, mdu_last;

  hz_mdu_timer #(.MDU_LAT(MDU_LAT)) u_mdu_timer (
    .clk   (clk),
    .rst   (rst),
    .start (mdu_start),
    .busy  (mdu_busy),
    .last  (mdu_last)
  );

  // Unused sources are zeroed so they can never match, here or later in EX.
  always_comb begin
    src_a      = hz.id_use_rs ? hz.id_rs : '0;
    src_b      = hz.id_use_rt ? hz.id_rt : '0;
    id_tag     = '{dst: hz.id_dst, rs: src_a, rt: src_b, regwrite: hz.id_regwrite,
                   load: hz.id_load, mdu: hz.id_mdu};
    ex_hit     = tag_match(src_a, ex_q)  | tag_match(src_b, ex_q);
    mem_hit    = tag_match(src_a, mem_q) | tag_match(src_b, mem_q);
    load_use   = ex_q.load & ex_hit;
    branch_dep = hz.id_branch & (ex_hit | (mem_q.load & mem_hit));
    mdu_hold   = mdu_busy & ~mdu_last;
    stall      = load_use | branch_dep | mdu_hold;
    flush      = hz.id_valid & hz.id_taken & ~stall;
    mdu_start  = hz.id_valid & hz.id_mdu & ~stall;
  end

  always_comb begin
    wb_d  = mem_q;
    mem_d = mdu_hold ? NOP_TAG : ex_q;
    if (mdu_hold)
      ex_d = ex_q;
    else if (stall || !hz.id_valid)
      ex_d = NOP_TAG;
    else
      ex_d = id_tag;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q  <= NOP_TAG;
      mem_q <= NOP_TAG;
      wb_q  <= NOP_TAG;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

  always_comb begin
    hz.pc_write     = ~stall;
    hz.ifid_write   = ~stall;
    hz.ifid_flush   = flush;
    hz.idex_bubble  = stall & ~mdu_hold;
    hz.ex_hold      = mdu_hold;
    hz.exmem_bubble = mdu_hold;
    hz.fwd_a_ex     = fwd_select(ex_q.rs, mem_q, wb_q);
    hz.fwd_b_ex     = fwd_select(ex_q.rt, mem_q, wb_q);
    hz.fwd_a_id     = fwd_select(src_a, mem_q, wb_q);
    hz.fwd_b_id     = fwd_select(src_b, mem_q, wb_q);
    hz.mdu_busy     = mdu_busy;
  end

`ifdef HAZ_PERF_CNT_EN
  localparam logic [CNTW-1:0] CNT_MAX = '1;

  logic [CNTW-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = (stall && stall_cnt_q != CNT_MAX) ? stall_cnt_q + CNTW'(1) : stall_cnt_q;
    flush_cnt_d = (flush && flush_cnt_q != CNT_MAX) ? flush_cnt_q + CNTW'(1) : flush_cnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  always_comb begin
    hz.stall_cnt = stall_cnt_q;
    hz.flush_cnt = flush_cnt_q;
  end
`endif

  // Tag fields that later stages carry but never consult.
  logic unused_tag_bits;
  assign unused_tag_bits = ^{ex_q.mdu, mem_q.rs, mem_q.rt, mem_q.mdu,
                             wb_q.rs, wb_q.rt, wb_q.load, wb_q.mdu};

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_scoreboard.sv
`default_nettype none
// =====================================================================
// tb_pipe_hazard_scoreboard : directed cycle-by-cycle vectors for the
// hazard scoreboard (counter checks when HAZ_PERF_CNT_EN is defined)
// Revision: 1.0
// =====================================================================
module tb_pipe_hazard_scoreboard;

  localparam logic [1:0] F0 = 2'b00;
  localparam logic [1:0] FW = 2'b01;
  localparam logic [1:0] FM = 2'b10;

  typedef struct {
    logic       v;
    logic [4:0] dst, rs, rt;
    logic       urs, urt, br, tk, rw, ld, mdu;
  } instr_t;

  typedef struct {
    instr_t      ins;
    logic [14:0] exp;
    string       name;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_hazard_scoreboard_if #(.RW(5)) hz();
  pipe_hazard_scoreboard #(.RW(5), .MDU_LAT(4)) dut (.clk(clk), .rst(rst), .hz(hz));

  vec_t vq[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic instr_t mk(logic v, logic [4:0] dst, logic [4:0] rs, logic [4:0] rt,
                                logic urs, logic urt, logic br, logic tk,
                                logic rw, logic ld, logic mdu);
    instr_t i;
    i.v = v; i.dst = dst; i.rs = rs; i.rt = rt; i.urs = urs; i.urt = urt;
    i.br = br; i.tk = tk; i.rw = rw; i.ld = ld; i.mdu = mdu;
    return i;
  endfunction

  function automatic instr_t nop_i();               return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); endfunction
  function automatic instr_t r_i(logic [4:0] d, logic [4:0] s, logic [4:0] t);
    return mk(1, d, s, t, 1, 1, 0, 0, 1, 0, 0);
  endfunction
  function automatic instr_t lw_i(logic [4:0] d, logic [4:0] s);
    return mk(1, d, s, 0, 1, 0, 0, 0, 1, 1, 0);
  endfunction
  function automatic instr_t beq_i(logic [4:0] s, logic [4:0] t, logic tk);
    return mk(1, 0, s, t, 1, 1, 1, tk, 0, 0, 0);
  endfunction
  function automatic instr_t mul_i(logic [4:0] d, logic [4:0] s, logic [4:0] t);
    return mk(1, d, s, t, 1, 1, 0, 0, 1, 0, 1);
  endfunction

  // {pc_write, ifid_write, ifid_flush, idex_bubble, ex_hold, exmem_bubble, mdu_busy,
  //  fwd_a_ex, fwd_b_ex, fwd_a_id, fwd_b_id}
  function automatic logic [14:0] e(logic pcw, logic ifw, logic fl, logic bub, logic hold,
                                    logic exb, logic busy, logic [1:0] fae, logic [1:0] fbe,
                                    logic [1:0] fai, logic [1:0] fbi);
    return {pcw, ifw, fl, bub, hold, exb, busy, fae, fbe, fai, fbi};
  endfunction

  function automatic logic [14:0] idle(logic [1:0] fae, logic [1:0] fbe,
                                       logic [1:0] fai, logic [1:0] fbi);
    return e(1, 1, 0, 0, 0, 0, 0, fae, fbe, fai, fbi);
  endfunction

  task automatic add(input instr_t i, input logic [14:0] x, input string n);
    vec_t v;
    v.ins = i; v.exp = x; v.name = n;
    vq.push_back(v);
  endtask

  task automatic drive(input instr_t i);
    hz.id_valid    = i.v;
    hz.id_rs       = i.rs;
    hz.id_rt       = i.rt;
    hz.id_use_rs   = i.urs;
    hz.id_use_rt   = i.urt;
    hz.id_branch   = i.br;
    hz.id_taken    = i.tk;
    hz.id_dst      = i.dst;
    hz.id_regwrite = i.rw;
    hz.id_load     = i.ld;
    hz.id_mdu      = i.mdu;
  endtask

  task automatic check(input string name, input logic [14:0] x);
    logic [14:0] act;
    act = {hz.pc_write, hz.ifid_write, hz.ifid_flush, hz.idex_bubble, hz.ex_hold,
           hz.exmem_bubble, hz.mdu_busy, hz.fwd_a_ex, hz.fwd_b_ex, hz.fwd_a_id, hz.fwd_b_id};
    n_vec++;
    if (act !== x) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (pcw ifw flush bub hold exb busy faex fbex faid fbid)",
               name, act, x);
    end
  endtask

`ifdef HAZ_PERF_CNT_EN
  task automatic check_cnt(input string name, input logic [15:0] act, input logic [15:0] x);
    n_vec++;
    if (act !== x) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, x);
    end
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [14:0] stl, hold;
    stl  = e(0, 0, 0, 1, 0, 0, 0, F0, F0, F0, F0);
    hold = e(0, 0, 0, 0, 1, 1, 1, F0, F0, F0, F0);

    // load-use
    add(lw_i(2, 1),      idle(F0, F0, F0, F0), "lw_then_add_c0");
    add(r_i(3, 2, 4),    stl,                  "load_use_stall");
    add(r_i(3, 2, 4),    idle(F0, F0, FM, F0), "load_use_release");
    add(nop_i(),         idle(FW, F0, F0, F0), "load_use_fwd_wb");
    add(nop_i(),         idle(F0, F0, F0, F0), "drain_a1");
    add(nop_i(),         idle(F0, F0, F0, F0), "drain_a2");
    // ALU-ALU forwarding, MEM vs WB
    add(r_i(2, 1, 1),    idle(F0, F0, F0, F0), "add2");
    add(r_i(5, 2, 2),    idle(F0, F0, F0, F0), "sub5_no_stall");
    add(r_i(6, 2, 5),    idle(FM, FM, FM, F0), "sub5_fwd_mem_both");
    add(nop_i(),         idle(FW, FM, F0, F0), "add6_wb_and_mem");
    add(r_i(2, 3, 3),    idle(F0, F0, F0, F0), "rewrite2_a");
    add(r_i(2, 4, 4),    idle(F0, F0, F0, F0), "rewrite2_b");
    add(r_i(8, 2, 2),    idle(F0, F0, FM, FM), "id_fwd_mem");
    add(nop_i(),         idle(FM, FM, F0, F0), "mem_beats_wb");
    add(nop_i(),         idle(F0, F0, F0, F0), "drain_b1");
    add(nop_i(),         idle(F0, F0, F0, F0), "drain_b2");
    // ALU result into a taken branch
    add(r_i(2, 1, 1),    idle(F0, F0, F0, F0), "add2_before_beq");
    add(beq_i(2, 0, 1),  stl,                  "beq_dep_stall");
    add(beq_i(2, 0, 1),  e(1, 1, 1, 0, 0, 0, 0, F0, F0, FM, F0), "beq_taken_flush");
    add(nop_i(),         idle(FW, F0, F0, F0), "flush_one_cycle");
    add(nop_i(),         idle(F0, F0, F0, F0), "drain_c1");
    // load into a branch: two stall cycles
    add(lw_i(2, 1),      idle(F0, F0, F0, F0), "lw_before_beq");
    add(beq_i(2, 3, 0),  stl,                  "lw_beq_stall1");
    add(beq_i(2, 3, 0),  e(0, 0, 0, 1, 0, 0, 0, F0, F0, FM, F0), "lw_beq_stall2");
    add(beq_i(2, 3, 0),  idle(F0, F0, FW, F0), "lw_beq_release_wb");
    add(nop_i(),         idle(F0, F0, F0, F0), "drain_d1");
    add(nop_i(),         idle(F0, F0, F0, F0), "drain_d2");
    // multi-cycle MDU
    add(mul_i(10, 8, 9), idle(F0, F0, F0, F0), "mul_issue");
    add(r_i(7, 10, 9),   hold,                 "mdu_hold1");
    add(r_i(7, 10, 9),   hold,                 "mdu_hold2");
    add(r_i(7, 10, 9),   hold,                 "mdu_hold3");
    add(r_i(7, 10, 9),   e(1, 1, 0, 0, 0, 0, 1, F0, F0, F0, F0), "mdu_last_cycle");
    add(nop_i(),         idle(FM, F0, F0, F0), "mul_fwd_from_mem");
    add(nop_i(),         idle(F0, F0, F0, F0), "drain_e1");
    // register 0
    add(r_i(0, 1, 1),    idle(F0, F0, F0, F0), "write_r0");
    add(r_i(1, 0, 0),    idle(F0, F0, F0, F0), "read_r0");
    add(r_i(3, 0, 1),    idle(F0, F0, F0, F0), "r0_no_id_fwd");
    add(nop_i(),         idle(F0, FM, F0, F0), "r0_no_ex_fwd");
    add(nop_i(),         idle(F0, F0, F0, F0), "drain_f1");
    add(nop_i(),         idle(F0, F0, F0, F0), "drain_f2");
    // unused source and invalid taken branch
    add(lw_i(4, 1),      idle(F0, F0, F0, F0), "lw4");
    add(mk(1, 5, 4, 0, 0, 0, 0, 0, 1, 0, 0), idle(F0, F0, F0, F0), "unused_rs_no_stall");
    add(nop_i(),         idle(F0, F0, F0, F0), "unused_rs_no_fwd");
    add(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0), idle(F0, F0, F0, F0), "invalid_taken_no_flush");

    rst = 1'b1;
    drive(nop_i());
    @(negedge clk);
    check("reset_state", idle(F0, F0, F0, F0));
`ifdef HAZ_PERF_CNT_EN
    check_cnt("reset_stall_cnt", 16'(hz.stall_cnt), 16'd0);
`endif
    rst = 1'b0;
    @(posedge clk); #1;

    foreach (vq[k]) begin
      drive(vq[k].ins);
      @(negedge clk);
      check(vq[k].name, vq[k].exp);
      @(posedge clk); #1;
    end

`ifdef HAZ_PERF_CNT_EN
    check_cnt("stall_cnt", 16'(hz.stall_cnt), 16'd7);
    check_cnt("flush_cnt", 16'(hz.flush_cnt), 16'd1);
`endif

    // reset asserted while the MDU holds EX
    drive(mul_i(10, 8, 9));
    @(negedge clk);
    check("rst_seq_mul_issue", idle(F0, F0, F0, F0));
    @(posedge clk); #1;
    drive(r_i(7, 10, 9));
    @(negedge clk);
    check("rst_seq_hold1", hold);
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_seq_hold2", hold);
    #2 rst = 1'b1;
    #1;
    check("rst_async_clears", idle(F0, F0, F0, F0));
`ifdef HAZ_PERF_CNT_EN
    check_cnt("rst_stall_cnt", 16'(hz.stall_cnt), 16'd0);
    check_cnt("rst_flush_cnt", 16'(hz.flush_cnt), 16'd0);
`endif
    @(posedge clk); #1;
    check("rst_held", idle(F0, F0, F0, F0));
    rst = 1'b0;
    drive(nop_i());
    @(negedge clk);
    check("after_rst_idle", idle(F0, F0, F0, F0));
    @(posedge clk); #1;
    drive(r_i(7, 10, 9));
    @(negedge clk);
    check("after_rst_no_hold", idle(F0, F0, F0, F0));
    @(posedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
